// File: rtl/sprite_overlay_n.sv
// N-channel sprite compositor: ROM addressing, latency-aligned delay,
// priority/colour-key compositing and per-frame collision latch.
//
// Ports:
//   pclk, rst (sync, active-low)
//   hcount_in/vcount_in, h/v sync/blank in, rgb_in : incoming picture
//   xpos/ypos (12b per channel), sprite_en          : sprite placement
//   rom_addr (out), rom_pixel (in)                  : per-channel ROM
//   *_out                                           : delayed timing + pixel
//   collision, frame_tick                           : per-frame overlap mask

module sprite_overlay_n #(
  parameter int          N       = 3,
  parameter int          SPR_W   = 64,
  parameter int          SPR_H   = 64,
  parameter int          ADDR_W  = 12,
  parameter int          ROM_LAT = 1,
  parameter logic [11:0] KEY     = 12'hF0F
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [11:0]         hcount_in,
  input  logic [11:0]         vcount_in,
  input  logic                hsync_in,
  input  logic                hblnk_in,
  input  logic                vsync_in,
  input  logic                vblnk_in,
  input  logic [11:0]         rgb_in,
  input  logic [N*12-1:0]     xpos,
  input  logic [N*12-1:0]     ypos,
  input  logic [N-1:0]        sprite_en,
  output logic [N*ADDR_W-1:0] rom_addr,
  input  logic [N*12-1:0]     rom_pixel,
  output logic [11:0]         hcount_out,
  output logic [11:0]         vcount_out,
  output logic                hsync_out,
  output logic                hblnk_out,
  output logic                vsync_out,
  output logic                vblnk_out,
  output logic [11:0]         rgb_out,
  output logic [N-1:0]        collision,
  output logic                frame_tick
);

  typedef struct packed {
    logic [11:0]  hc;
    logic [11:0]  vc;
    logic         hs;
    logic         hb;
    logic         vs;
    logic         vb;
    logic [11:0]  rgb;
    logic [N-1:0] act;
  } pix_t;

  logic              vblnk_d;
  logic [N*12-1:0]   sx;
  logic [N*12-1:0]   sy;
  logic [N-1:0]      sen;
  pix_t              pipe [ROM_LAT+1];
  logic [N-1:0]      acc;

  logic [N-1:0]        in_a;
  logic [N*ADDR_W-1:0] addr_a;

  // Stage A: 13-bit compares so x+SPR_W cannot wrap past 4095.
  always_comb begin
    logic [12:0]       h13;
    logic [12:0]       v13;
    logic [12:0]       x13;
    logic [12:0]       y13;
    logic [12:0]       dx;
    logic [12:0]       dy;
    logic [ADDR_W-1:0] lin;
    logic              hit;
    in_a   = '0;
    addr_a = '0;
    h13    = {1'b0, hcount_in};
    v13    = {1'b0, vcount_in};
    x13    = '0;
    y13    = '0;
    dx     = '0;
    dy     = '0;
    lin    = '0;
    hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      x13 = {1'b0, sx[12*i +: 12]};
      y13 = {1'b0, sy[12*i +: 12]};
      dx  = h13 - x13;
      dy  = v13 - y13;
      hit = (h13 >= x13) && (h13 < x13 + 13'(SPR_W)) &&
            (v13 >= y13) && (v13 < y13 + 13'(SPR_H));
      lin = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
      in_a[i] = sen[i] & hit;
      if (in_a[i]) addr_a[ADDR_W*i +: ADDR_W] = lin;
    end
  end

  pix_t         c_in;
  logic [N-1:0] opaque;
  logic [11:0]  rgb_c;
  logic [N-1:0] hit_c;
  logic         blank_c;
  logic         multi_c;
  logic         vb_rise;

  assign c_in = pipe[ROM_LAT];

  // Stage C: lowest index wins, so scan from the top down.
  always_comb begin
    opaque = '0;
    for (int i = 0; i < N; i++) begin
      opaque[i] = c_in.act[i] && (rom_pixel[12*i +: 12] != KEY);
    end
    rgb_c = c_in.rgb;
    for (int i = N - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_c = rom_pixel[12*i +: 12];
    end
    blank_c = c_in.hb | c_in.vb;
    if (blank_c) rgb_c = '0;
    multi_c = |(opaque & (opaque - N'(1)));
    hit_c   = (!blank_c && multi_c) ? opaque : '0;
    // vblnk_out holds the previous stage-C vblnk.
    vb_rise = c_in.vb & ~vblnk_out;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      vblnk_d    <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      sen        <= '0;
      rom_addr   <= '0;
      for (int k = 0; k <= ROM_LAT; k++) pipe[k] <= '0;
      acc        <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      collision  <= '0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d <= vblnk_in;
      if (vblnk_in && !vblnk_d) begin
        sx  <= xpos;
        sy  <= ypos;
        sen <= sprite_en;
      end
      rom_addr <= addr_a;
      pipe[0]  <= '{hc: hcount_in, vc: vcount_in,
                    hs: hsync_in, hb: hblnk_in,
                    vs: vsync_in, vb: vblnk_in,
                    rgb: rgb_in, act: in_a};
      for (int k = 1; k <= ROM_LAT; k++) pipe[k] <= pipe[k-1];
      hcount_out <= c_in.hc;
      vcount_out <= c_in.vc;
      hsync_out  <= c_in.hs;
      hblnk_out  <= c_in.hb;
      vsync_out  <= c_in.vs;
      vblnk_out  <= c_in.vb;
      rgb_out    <= rgb_c;
      if (vb_rise) begin
        collision  <= acc | hit_c;
        acc        <= '0;
        frame_tick <= 1'b1;
      end else begin
        acc        <= acc | hit_c;
        frame_tick <= 1'b0;
      end
    end
  end

endmodule
